// File: rtl/graphics_blit_engine.sv
// graphics_blit_engine: bus-side framebuffer port with a fill/copy engine.
// BRAM port A is shared between the bus (phase-0 accesses) and the engine.
// Optional copy mode is enabled by defining GFX_BLIT_COPY_EN; without it only
// fill, scroll and plain bus accesses are available.
module graphics_blit_engine #(
  parameter int unsigned DEPTH    = 60000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned BPP      = 4,
  parameter int unsigned CFG_BASE = DEPTH
) (
  input  logic              bus_clk_2x,
  input  logic              rst,
  input  logic              bus_phase,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [31:0]       bus_address,
  input  logic [31:0]       bus_data_wr,
  output logic [31:0]       bus_data_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       scroll_offset,
  output logic              busy,
  output logic              irq
);

  localparam logic [31:0] DEPTH_W      = 32'(DEPTH);
  localparam logic [31:0] CFG_W        = 32'(CFG_BASE);
  localparam int unsigned PIX_PER_WORD = 32 / BPP;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
`ifdef GFX_BLIT_COPY_EN
    ,
    ST_CP_RD,
    ST_CP_LAT,
    ST_CP_WR
`endif
  } state_t;

  state_t state, state_next;

  logic [31:0]      dst;
  logic [31:0]      len;
  logic [BPP-1:0]   fill_px;
  logic [31:0]      fill_word;
  logic [31:0]      src_rd;
`ifdef GFX_BLIT_COPY_EN
  logic [31:0]      src;
  logic [31:0]      copy_buf;
  logic             lat_cnt;
  logic             start_copy;
  logic             buf_load;
`endif

  logic [31:0]       cfg_off;
  logic              cfg_hit;
  logic [2:0]        cfg_idx;
  logic              reg_wr;
  logic              ctrl_wr;
  logic              start_fill;
  logic              steal;
  logic              eng_valid;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_din;
  logic              advance;

  // Wrapping helpers: pointers live in [0, DEPTH).
  function automatic logic [31:0] reduce(input logic [31:0] x);
    return (x >= DEPTH_W) ? x - DEPTH_W : x;
  endfunction

  function automatic logic [31:0] wrap_inc(input logic [31:0] x);
    return (x >= DEPTH_W - 32'd1) ? '0 : x + 32'd1;
  endfunction

  assign cfg_off    = bus_address - CFG_W;
  assign cfg_hit    = (bus_address >= CFG_W) && (cfg_off < 32'd6);
  assign cfg_idx    = cfg_off[2:0];
  assign reg_wr     = !bus_phase && bus_write && cfg_hit;
  assign ctrl_wr    = reg_wr && (cfg_idx == 3'd4);
  assign start_fill = ctrl_wr && bus_data_wr[0] && (state == ST_IDLE);
`ifdef GFX_BLIT_COPY_EN
  assign start_copy = ctrl_wr && bus_data_wr[1] && !bus_data_wr[0] && (state == ST_IDLE);
  assign src_rd     = src;
`else
  assign src_rd     = '0;
`endif

  assign steal         = !bus_phase && (bus_read || bus_write) && (bus_address < DEPTH_W);
  assign fill_word     = {PIX_PER_WORD{fill_px}};
  assign busy          = (state != ST_IDLE);

  // FSM state register.
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state and engine port-A request; a bus steal freezes the engine.
  always_comb begin
    state_next = state;
    eng_valid  = 1'b0;
    eng_we     = 1'b0;
    eng_addr   = dst[ADDR_W-1:0];
    eng_din    = fill_word;
    advance    = 1'b0;
`ifdef GFX_BLIT_COPY_EN
    buf_load   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_fill)
          state_next = (len == 32'd0) ? ST_DONE : ST_FILL;
`ifdef GFX_BLIT_COPY_EN
        else if (start_copy)
          state_next = (len == 32'd0) ? ST_DONE : ST_CP_RD;
`endif
      end
      ST_FILL: begin
        eng_valid = 1'b1;
        eng_we    = 1'b1;
        if (!steal) begin
          advance = 1'b1;
          if (len == 32'd1) state_next = ST_DONE;
        end
      end
`ifdef GFX_BLIT_COPY_EN
      ST_CP_RD: begin
        eng_valid = 1'b1;
        eng_addr  = src[ADDR_W-1:0];
        if (!steal) state_next = ST_CP_LAT;
      end
      // Read latency wait does not use the port, so it never stalls.
      ST_CP_LAT: begin
        if (lat_cnt) begin
          buf_load   = 1'b1;
          state_next = ST_CP_WR;
        end
      end
      ST_CP_WR: begin
        eng_valid = 1'b1;
        eng_we    = 1'b1;
        eng_din   = copy_buf;
        if (!steal) begin
          advance    = 1'b1;
          state_next = (len == 32'd1) ? ST_DONE : ST_CP_RD;
        end
      end
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Configuration registers and engine pointers/counters.
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      scroll_offset <= '0;
      dst           <= '0;
      len           <= '0;
      fill_px       <= '0;
`ifdef GFX_BLIT_COPY_EN
      src           <= '0;
`endif
    end else begin
      if (reg_wr && cfg_idx == 3'd0) scroll_offset <= bus_data_wr;
      if (reg_wr && state == ST_IDLE) begin
        case (cfg_idx)
          3'd1: dst     <= bus_data_wr;
          3'd2: len     <= bus_data_wr;
          3'd3: fill_px <= bus_data_wr[BPP-1:0];
`ifdef GFX_BLIT_COPY_EN
          3'd5: src     <= bus_data_wr;
`endif
          default: ;
        endcase
      end
`ifdef GFX_BLIT_COPY_EN
      if (start_fill || start_copy) begin
        dst <= reduce(dst);
        src <= reduce(src);
      end
      if (advance && state == ST_CP_WR) src <= wrap_inc(src);
`else
      if (start_fill) dst <= reduce(dst);
`endif
      if (advance) begin
        dst <= wrap_inc(dst);
        len <= len - 32'd1;
      end
    end
  end

  // Sticky done flag; a CTRL clear loses to a same-cycle completion.
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst)                              irq <= 1'b0;
    else if (state == ST_DONE)            irq <= 1'b1;
    else if (ctrl_wr && bus_data_wr[2])   irq <= 1'b0;
  end

`ifdef GFX_BLIT_COPY_EN
  // Copy read-latency counter and data buffer.
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      lat_cnt  <= 1'b0;
      copy_buf <= '0;
    end else begin
      lat_cnt <= (state == ST_CP_LAT) ? ~lat_cnt : 1'b0;
      if (buf_load) copy_buf <= mem_dout;
    end
  end
`endif

  // Port A mux: bus phase-0 access beats the engine.
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (steal) begin
      mem_we   <= bus_write;
      mem_addr <= bus_address[ADDR_W-1:0];
      mem_din  <= bus_data_wr;
    end else if (eng_valid) begin
      mem_we   <= eng_we;
      mem_addr <= eng_addr;
      mem_din  <= eng_din;
    end else begin
      mem_we   <= 1'b0;
    end
  end

  // Combinational bus read data: registers in the config window, else BRAM.
  always_comb begin
    bus_data_rd = '0;
    if (bus_read) begin
      if (cfg_hit) begin
        case (cfg_idx)
          3'd0:    bus_data_rd = scroll_offset;
          3'd1:    bus_data_rd = dst;
          3'd2:    bus_data_rd = len;
          3'd3:    bus_data_rd = {{(32-BPP){1'b0}}, fill_px};
          3'd4:    bus_data_rd = {30'b0, irq, busy};
          3'd5:    bus_data_rd = src_rd;
          default: bus_data_rd = '0;
        endcase
      end else begin
        bus_data_rd = mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_graphics_blit_engine.sv
// Testbench for graphics_blit_engine: directed cases plus randomized fill/copy
// operations with random bus traffic, checked against a word-array model.
module tb_graphics_blit_engine;

  localparam int unsigned D  = 1000;
  localparam int unsigned AW = 10;
  localparam logic [31:0] CB       = 32'(D);
  localparam logic [31:0] R_SCROLL = CB;
  localparam logic [31:0] R_DST    = CB + 32'd1;
  localparam logic [31:0] R_LEN    = CB + 32'd2;
  localparam logic [31:0] R_FILL   = CB + 32'd3;
  localparam logic [31:0] R_CTRL   = CB + 32'd4;
  localparam logic [31:0] R_SRC    = CB + 32'd5;

  logic          bus_clk_2x = 1'b0;
  logic          rst = 1'b1;
  logic          bus_phase = 1'b0;
  logic          bus_read = 1'b0;
  logic          bus_write = 1'b0;
  logic [31:0]   bus_address = '0;
  logic [31:0]   bus_data_wr = '0;
  logic [31:0]   bus_data_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = '0;
  logic [31:0]   scroll_offset;
  logic          busy;
  logic          irq;

  logic [31:0] bram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:D-1];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned busy_edges = 0;
  int unsigned we_count = 0;

  always #5 bus_clk_2x = ~bus_clk_2x;

  graphics_blit_engine #(
    .DEPTH(D), .ADDR_W(AW), .BPP(4), .CFG_BASE(D)
  ) dut (
    .bus_clk_2x(bus_clk_2x), .rst(rst), .bus_phase(bus_phase),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_data_wr(bus_data_wr), .bus_data_rd(bus_data_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .scroll_offset(scroll_offset), .busy(busy), .irq(irq)
  );

  // BRAM port A model: read-first, one clock read latency.
  always @(posedge bus_clk_2x) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  always @(posedge bus_clk_2x) begin
    if (busy)   busy_edges++;
    if (mem_we) we_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge bus_clk_2x);
    bus_phase = ~bus_phase;
    bus_read  = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic to_phase0();
    nxt();
    if (bus_phase) nxt();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    to_phase0();
    bus_write   = 1'b1;
    bus_address = a;
    bus_data_wr = d;
    nxt();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    to_phase0();
    bus_read    = 1'b1;
    bus_address = a;
    @(negedge bus_clk_2x);
    bus_phase = 1'b1;
    @(posedge bus_clk_2x);
    #1;
    d = bus_data_rd;
  endtask

  function automatic bit in_rng(input int unsigned a, input int unsigned base, input int unsigned n);
    return ((a + D - base) % D) < n;
  endfunction

  function automatic int unsigned mem_diffs();
    int unsigned n = 0;
    for (int unsigned i = 0; i < D; i++)
      if (bram[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Wait for the engine to finish, optionally injecting bus writes to words
  // outside the active ranges (those are recorded in the model directly).
  task automatic wait_idle(input bit inject, input int unsigned r0, input int unsigned n0,
                           input int unsigned r1, input int unsigned n1);
    int unsigned cyc = 0;
    while (busy && cyc < 3000) begin
      nxt();
      cyc++;
      if (inject && !bus_phase && $urandom_range(0, 3) == 0) begin
        int unsigned a;
        logic [31:0] v;
        a = $urandom_range(0, D - 1);
        v = $urandom;
        if (!in_rng(a, r0, n0) && !in_rng(a, r1, n1)) begin
          bus_write   = 1'b1;
          bus_address = a;
          bus_data_wr = v;
          ref_mem[a]  = v;
        end
      end
    end
    check("engine_timeout", {31'b0, busy}, 32'd0);
    repeat (3) nxt();
  endtask

  initial begin
    logic [31:0] rd;
    for (int unsigned i = 0; i < (1 << AW); i++) bram[i] = '0;
    for (int unsigned i = 0; i < D; i++) ref_mem[i] = '0;

    // Reset state.
    repeat (3) nxt();
    rst = 1'b0;
    nxt();
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_scroll", scroll_offset, 32'd0);
    bus_rd(R_CTRL, rd);
    check("rst_ctrl_rd", rd, 32'd0);

    // Scroll register.
    bus_wr(R_SCROLL, 32'd1600);
    check("scroll_out", scroll_offset, 32'd1600);
    bus_rd(R_SCROLL, rd);
    check("scroll_rd", rd, 32'd1600);

    // Basic fill with timing.
    bus_wr(R_FILL, 32'hA);
    bus_wr(R_DST, 32'd10);
    bus_wr(R_LEN, 32'd3);
    busy_edges = 0;
    bus_wr(R_CTRL, 32'd1);
    for (int unsigned i = 10; i < 13; i++) ref_mem[i] = 32'hAAAA_AAAA;
    wait_idle(1'b0, 0, 0, 0, 0);
    check("fill_clks", busy_edges + 32'd1, 32'd5);
    check("fill_mem", mem_diffs(), 32'd0);
    bus_rd(R_CTRL, rd);
    check("fill_ctrl", rd, 32'd2);
    bus_rd(32'd11, rd);
    check("fill_bus_rd", rd, 32'hAAAA_AAAA);
    bus_wr(R_CTRL, 32'd4);
    bus_rd(R_CTRL, rd);
    check("irq_clear", rd, 32'd0);

    // Wrap at the end of the framebuffer.
    bus_wr(R_FILL, 32'h3);
    bus_wr(R_DST, D - 1);
    bus_wr(R_LEN, 32'd2);
    bus_wr(R_CTRL, 32'd1);
    ref_mem[D-1] = 32'h3333_3333;
    ref_mem[0]   = 32'h3333_3333;
    wait_idle(1'b0, 0, 0, 0, 0);
    check("wrap_mem", mem_diffs(), 32'd0);

    // Bus steal during a long fill; start+clear clears irq; busy writes ignored.
    bus_wr(R_FILL, 32'h5);
    bus_wr(R_DST, 32'd0);
    bus_wr(R_LEN, 32'd50);
    busy_edges = 0;
    bus_wr(R_CTRL, 32'd5);
    bus_wr(32'd500, 32'h1234_5678);
    bus_rd(R_CTRL, rd);
    check("start_clr_ctrl", rd, 32'd1);
    bus_wr(R_DST, 32'd7);
    bus_wr(R_CTRL, 32'd1);
    for (int unsigned i = 0; i < 50; i++) ref_mem[i] = 32'h5555_5555;
    ref_mem[500] = 32'h1234_5678;
    wait_idle(1'b0, 0, 0, 0, 0);
    check("steal_clks", busy_edges, 32'd52);
    check("steal_mem", mem_diffs(), 32'd0);
    bus_rd(R_DST, rd);
    check("steal_dst", rd, 32'd50);
    bus_rd(32'd500, rd);
    check("steal_word", rd, 32'h1234_5678);

    // Zero-length start goes straight to done.
    bus_wr(R_LEN, 32'd0);
    busy_edges = 0;
    bus_wr(R_CTRL, 32'd5);
    wait_idle(1'b0, 0, 0, 0, 0);
    check("zero_clks", busy_edges, 32'd1);
    bus_rd(R_CTRL, rd);
    check("zero_ctrl", rd, 32'd2);

`ifdef GFX_BLIT_COPY_EN
    // Copy of a known pattern.
    for (int unsigned i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      bus_wr(i, v);
      ref_mem[i] = v;
    end
    bus_wr(R_SRC, 32'd0);
    bus_wr(R_DST, 32'd100);
    bus_wr(R_LEN, 32'd4);
    busy_edges = 0;
    bus_wr(R_CTRL, 32'd6);
    for (int unsigned i = 0; i < 4; i++) ref_mem[100+i] = ref_mem[i];
    wait_idle(1'b0, 0, 0, 0, 0);
    check("copy_clks", busy_edges, 32'd17);
    check("copy_mem", mem_diffs(), 32'd0);
    bus_rd(R_CTRL, rd);
    check("copy_ctrl", rd, 32'd2);
    bus_rd(32'd102, rd);
    check("copy_word", rd, ref_mem[2]);
`else
    // Copy disabled: copy start ignored, SRC reads zero.
    bus_wr(R_LEN, 32'd4);
    busy_edges = 0;
    bus_wr(R_CTRL, 32'd2);
    repeat (4) nxt();
    check("nocopy_idle", busy_edges, 32'd0);
    bus_wr(R_SRC, 32'd123);
    bus_rd(R_SRC, rd);
    check("nocopy_src", rd, 32'd0);
`endif

    // Randomized operations with concurrent bus traffic.
    for (int it = 0; it < 12; it++) begin
      int unsigned d, s, n, dr, sr;
      logic [3:0] px;
      bit cp;
      d  = $urandom_range(0, 2*D - 1);
      s  = $urandom_range(0, 2*D - 1);
      n  = $urandom_range(0, 40);
      px = 4'($urandom);
      dr = d % D;
      sr = s % D;
      cp = 1'b0;
`ifdef GFX_BLIT_COPY_EN
      cp = 1'($urandom_range(0, 1));
`endif
      bus_wr(R_DST, d);
      bus_wr(R_LEN, n);
      if (cp) bus_wr(R_SRC, s);
      else    bus_wr(R_FILL, {28'b0, px});
      for (int unsigned i = 0; i < n; i++) begin
        if (cp) ref_mem[(dr + i) % D] = ref_mem[(sr + i) % D];
        else    ref_mem[(dr + i) % D] = {8{px}};
      end
      bus_wr(R_CTRL, cp ? 32'd6 : 32'd5);
      wait_idle(1'b1, dr, n, sr, cp ? n : 0);
      check("rand_mem", mem_diffs(), 32'd0);
      bus_rd(R_CTRL, rd);
      check("rand_ctrl", rd, 32'd2);
      bus_rd(R_DST, rd);
      check("rand_dst", rd, (dr + n) % D);
    end

    // Asynchronous reset in the middle of a fill.
    bus_wr(R_FILL, 32'h9);
    bus_wr(R_DST, 32'd200);
    bus_wr(R_LEN, 32'd300);
    bus_wr(R_CTRL, 32'd1);
    repeat (10) nxt();
    #2 rst = 1'b1;
    #1;
    check("arst_mem_we", {31'b0, mem_we}, 32'd0);
    check("arst_mem_addr", {22'b0, mem_addr}, 32'd0);
    check("arst_mem_din", mem_din, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_scroll", scroll_offset, 32'd0);
    check("arst_rd", bus_data_rd, 32'd0);
    repeat (3) nxt();
    rst = 1'b0;
    we_count = 0;
    repeat (20) nxt();
    check("arst_no_we", we_count, 32'd0);
    bus_rd(R_LEN, rd);
    check("arst_len", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
